sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between display read bursts and
// compute-engine write bursts. An urgency override is bounded by MAX_URGENT.
module sdram_arbiter #(
    parameter int unsigned RD_BURST    = 8,
    parameter int unsigned WR_BURST    = 8,
    parameter int unsigned FRAME_WORDS = 96000,
    parameter int unsigned MAX_URGENT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        rd_urgent,
    input  logic        rd_ptr_reset,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_req,
    input  logic [21:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_next,
    output logic        wr_burst_done,
    output logic [1:0]  mem_cmd,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rd_valid,
    input  logic        mem_wr_done
);
    // Enum values double as the controller command encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

    localparam logic [15:0] RdLast    = 16'(RD_BURST - 1);
    localparam logic [15:0] WrLast    = 16'(WR_BURST - 1);
    localparam logic [21:0] PtrLast   = 22'(FRAME_WORDS - 1);
    localparam logic [7:0]  StreakMax = 8'(MAX_URGENT);

    state_e      state_q, state_d;
    logic        rdy_q;
    logic        last_wr_q, last_wr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  streak_q, streak_d;
    logic [21:0] rd_ptr_q, rd_ptr_d;
    logic [21:0] wr_addr_q, wr_addr_d;
    logic [21:0] mem_addr_q;
    logic        ptr_pend_q, ptr_pend_d;
    logic        urgent_win;
    logic        grant_rd;
    logic        grant_wr;

    assign mem_cmd   = state_q;
    assign rd_data   = mem_rdata;
    assign mem_wdata = wr_data;

    always_comb begin
        state_d       = state_q;
        last_wr_d     = last_wr_q;
        cnt_d         = cnt_q;
        streak_d      = streak_q;
        rd_ptr_d      = rd_ptr_q;
        wr_addr_d     = wr_addr_q;
        ptr_pend_d    = ptr_pend_q;
        mem_addr      = mem_addr_q;
        rd_valid      = 1'b0;
        wr_next       = 1'b0;
        wr_burst_done = 1'b0;
        urgent_win    = rd_req && rd_urgent && !(wr_req && (streak_q == StreakMax));
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rd_ptr_reset) begin
                    rd_ptr_d = '0;
                end
                // rdy_q holds off decisions until the first edge after reset has passed.
                if (rdy_q) begin
                    if (urgent_win) begin
                        grant_rd = 1'b1;
                    end else if (rd_req && wr_req) begin
                        grant_rd = last_wr_q;
                        grant_wr = !last_wr_q;
                    end else begin
                        grant_rd = rd_req;
                        grant_wr = wr_req;
                    end
                end
                if (grant_rd) begin
                    state_d   = StRead;
                    cnt_d     = RdLast;
                    last_wr_d = 1'b0;
                    if (!rd_urgent) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 8'd1;
                    end
                end else if (grant_wr) begin
                    state_d   = StWrite;
                    cnt_d     = WrLast;
                    last_wr_d = 1'b1;
                    streak_d  = '0;
                    wr_addr_d = wr_addr;
                end
            end
            StRead: begin
                mem_addr = rd_ptr_q;
                rd_valid = mem_rd_valid;
                if (rd_ptr_reset) begin
                    ptr_pend_d = 1'b1;
                end
                if (mem_rd_valid) begin
                    rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 22'd1;
                    cnt_d    = cnt_q - 16'd1;
                    if (cnt_q == '0) begin
                        state_d    = StIdle;
                        cnt_d      = '0;
                        ptr_pend_d = 1'b0;
                        if (ptr_pend_q || rd_ptr_reset) begin
                            rd_ptr_d = '0;
                        end
                    end
                end
            end
            StWrite: begin
                mem_addr = wr_addr_q;
                if (rd_ptr_reset) begin
                    rd_ptr_d = '0;
                end
                if (mem_wr_done) begin
                    wr_next   = 1'b1;
                    wr_addr_d = wr_addr_q + 22'd1;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == '0) begin
                        wr_burst_done = 1'b1;
                        state_d       = StIdle;
                        cnt_d         = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rdy_q      <= 1'b0;
            last_wr_q  <= 1'b1;
            cnt_q      <= '0;
            streak_q   <= '0;
            rd_ptr_q   <= '0;
            wr_addr_q  <= '0;
            mem_addr_q <= '0;
            ptr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            last_wr_q  <= last_wr_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_addr_q  <= wr_addr_d;
            mem_addr_q <= mem_addr;
            ptr_pend_q <= ptr_pend_d;
        end
    end

endmodule
